// File: rtl/depth_resolve_scan_if.sv
// rtl/depth_resolve_scan_if.sv - evaluator bus and output pixel stream of the depth resolver
interface depth_resolve_scan_if #(
   parameter int COORD_W  = 11,
   parameter int Z_W      = 20,
   parameter int COLOR_W  = 24,
   parameter int NUM_SURF = 4
);
   logic [COORD_W-1:0]          eval_x;
   logic [COORD_W-1:0]          eval_y;
   logic                        eval_valid;
   logic [NUM_SURF*Z_W-1:0]     surf_z;
   logic [NUM_SURF*COLOR_W-1:0] surf_color;
   logic [NUM_SURF-1:0]         surf_hit;
   logic [COORD_W-1:0]          pix_x;
   logic [COORD_W-1:0]          pix_y;
   logic [COLOR_W-1:0]          pix_color;
   logic                        pix_valid;
   logic                        pix_last;
   logic                        pix_ready;

   modport master (
      output eval_x, eval_y, eval_valid,
      input  surf_z, surf_color, surf_hit,
      output pix_x, pix_y, pix_color, pix_valid, pix_last,
      input  pix_ready
   );

   modport slave (
      input  eval_x, eval_y, eval_valid,
      output surf_z, surf_color, surf_hit,
      input  pix_x, pix_y, pix_color, pix_valid, pix_last,
      output pix_ready
   );
endinterface

// File: rtl/depth_resolve_scan.sv
// rtl/depth_resolve_scan.sv - raster scanner with pipelined nearest-surface depth resolve
module depth_resolve_scan #(
   parameter int               H_RES    = 640,
   parameter int               V_RES    = 480,
   parameter int               NUM_SURF = 4,
   parameter int               Z_W      = 20,
   parameter int               COLOR_W  = 24,
   parameter int               COORD_W  = 11,
   parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic draw_surface_start,
   output logic busy,
   output logic draw_surface_done,
   depth_resolve_scan_if.master bus
);

   // number of registered pairwise compare levels between stage 0 and the output register
   localparam int CMP_STAGES = (NUM_SURF > 1) ? $clog2(NUM_SURF) : 0;
   // lane arrays are twice as wide so the odd partner index of any lane stays in range
   localparam int LANES = 2 * NUM_SURF;
   localparam logic signed [Z_W-1:0] Z_MIN = {1'b1, {(Z_W-1){1'b0}}};
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

   typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

   state_t state, state_nxt;
   logic [COORD_W-1:0] cnt_x, cnt_y;
   logic adv;
   logic at_end;

   // level 0 is the registered evaluator sample, levels 1..CMP_STAGES the compare tree
   logic signed [Z_W-1:0] lz [0:CMP_STAGES][0:LANES-1];
   logic [COLOR_W-1:0]    lc [0:CMP_STAGES][0:LANES-1];
   logic                  lh [0:CMP_STAGES][0:LANES-1];
   logic                  vld [0:CMP_STAGES];
   logic [COORD_W-1:0]    cx [0:CMP_STAGES];
   logic [COORD_W-1:0]    cy [0:CMP_STAGES];

   // live lanes at a tree level: each level halves the count, an odd lane rides along
   function automatic int lanes_at(input int lvl);
      int n;
      n = NUM_SURF;
      for (int j = 0; j < lvl; j++) n = (n + 1) / 2;
      return n;
   endfunction

   assign adv        = !bus.pix_valid || bus.pix_ready;
   assign at_end     = (cnt_x == X_LAST) && (cnt_y == Y_LAST);
   assign bus.eval_x = cnt_x;
   assign bus.eval_y = cnt_y;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state and status outputs; a start outside IDLE is simply not looked at
   always_comb begin
      state_nxt         = state;
      bus.eval_valid    = 1'b0;
      busy              = 1'b1;
      draw_surface_done = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (draw_surface_start) state_nxt = SCAN;
         end
         SCAN: begin
            bus.eval_valid = 1'b1;
            if (adv && at_end) state_nxt = FLUSH;
         end
         FLUSH: begin
            if (bus.pix_valid && bus.pix_ready && bus.pix_last) state_nxt = DONE;
         end
         DONE: begin
            draw_surface_done = 1'b1;
            state_nxt         = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // raster counters; they wrap to (0,0) after the last pixel so IDLE always starts clean
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_x <= '0;
         cnt_y <= '0;
      end else if (state == IDLE) begin
         cnt_x <= '0;
         cnt_y <= '0;
      end else if (state == SCAN && adv) begin
         if (cnt_x == X_LAST) begin
            cnt_x <= '0;
            cnt_y <= (cnt_y == Y_LAST) ? '0 : cnt_y + 1'b1;
         end else begin
            cnt_x <= cnt_x + 1'b1;
         end
      end
   end

   // resolve pipeline: sample, pairwise compare tree, output register; all hold while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k <= CMP_STAGES; k++) begin
            vld[k] <= 1'b0;
            cx[k]  <= '0;
            cy[k]  <= '0;
            for (int i = 0; i < LANES; i++) begin
               lz[k][i] <= Z_MIN;
               lc[k][i] <= BG_COLOR;
               lh[k][i] <= 1'b0;
            end
         end
         bus.pix_valid <= 1'b0;
         bus.pix_x     <= '0;
         bus.pix_y     <= '0;
         bus.pix_color <= '0;
         bus.pix_last  <= 1'b0;
      end else if (adv) begin
         vld[0] <= bus.eval_valid;
         cx[0]  <= bus.eval_x;
         cy[0]  <= bus.eval_y;
         for (int i = 0; i < NUM_SURF; i++) begin
            lh[0][i] <= bus.surf_hit[i];
            lz[0][i] <= bus.surf_hit[i] ? bus.surf_z[i*Z_W +: Z_W] : Z_MIN;
            lc[0][i] <= bus.surf_hit[i] ? bus.surf_color[i*COLOR_W +: COLOR_W] : BG_COLOR;
         end
         for (int k = 1; k <= CMP_STAGES; k++) begin
            vld[k] <= vld[k-1];
            cx[k]  <= cx[k-1];
            cy[k]  <= cy[k-1];
            for (int i = 0; i < NUM_SURF; i++) begin
               if (i < lanes_at(k)) begin
                  // the right lane (higher index) wins only if it hits and is strictly nearer,
                  // or if it hits while the left lane does not
                  if (((2*i + 1) < lanes_at(k-1)) && lh[k-1][2*i+1] &&
                      (!lh[k-1][2*i] || (lz[k-1][2*i+1] > lz[k-1][2*i]))) begin
                     lz[k][i] <= lz[k-1][2*i+1];
                     lc[k][i] <= lc[k-1][2*i+1];
                     lh[k][i] <= 1'b1;
                  end else begin
                     lz[k][i] <= lz[k-1][2*i];
                     lc[k][i] <= lc[k-1][2*i];
                     lh[k][i] <= lh[k-1][2*i];
                  end
               end
            end
         end
         bus.pix_valid <= vld[CMP_STAGES];
         bus.pix_x     <= cx[CMP_STAGES];
         bus.pix_y     <= cy[CMP_STAGES];
         bus.pix_color <= lc[CMP_STAGES][0];
         bus.pix_last  <= vld[CMP_STAGES] && (cx[CMP_STAGES] == X_LAST) &&
                          (cy[CMP_STAGES] == Y_LAST);
      end
   end

endmodule
